// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose:
//   Turns a valid/ready command stream into APB4 transfers (SETUP -> ACCESS,
//   waiting on PREADY) and returns the read data / error status on a
//   valid/ready response channel. One transfer is outstanding at a time.
//
// Handshake rule (both channels): a beat moves on a rising PCLK edge where
//   valid and ready are both 1. cmd_ready is 1 only in IDLE; rsp_valid is 1
//   only in RESP and the response stays stable until it is consumed.
//
// Ports:
//   PCLK, PRESET            clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write               1 = write, 0 = read
//   cmd_addr                byte address, forwarded to PADDR unchanged
//   cmd_wdata, cmd_strb     write data and byte strobes
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata               read data (0 for writes and timeouts)
//   rsp_err                 PSLVERR of the transfer, or timeout
//   PSEL..PSTRB             APB master-side outputs
//   PRDATA, PREADY, PSLVERR APB slave-side inputs
//   state_dbg               one-hot FSM state (IDLE=0001 SETUP=0010
//                           ACCESS=0100 RESP=1000)
//
// Configuration:
//   APB_TIMEOUT_EN  when defined, ACCESS is abandoned after TIMEOUT_CYCLES
//                   cycles without PREADY and an error response is returned.
//                   When undefined, ACCESS waits for PREADY indefinitely.
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NBYTES         = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [NBYTES-1:0]     cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [NBYTES-1:0]     PSTRB,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic [3:0]            state_dbg
);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        SETUP  = 4'b0010,
        ACCESS = 4'b0100,
        RESP   = 4'b1000
    } state_t;

    state_t state;

    // The wait counter is 8 bits wide, so the timeout must fit in 1..255.
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_range
        $error("apb_master_bridge: TIMEOUT_CYCLES must be in 1..255");
    end

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`endif

    assign state_dbg = state;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
`ifdef APB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready is 1 throughout IDLE, so cmd_valid alone
                    // completes the handshake here.
                    if (cmd_valid) begin
                        PADDR     <= cmd_addr;
                        PWRITE    <= cmd_write;
                        PWDATA    <= cmd_wdata;
                        PSTRB     <= cmd_write ? cmd_strb : '0;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end

                ACCESS: begin
                    // A ready slave always wins over a timeout in the same cycle.
                    if (PREADY) begin
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed and randomized transfers through apb_master_bridge. The bench plays
// the APB slave (a 16-word memory indexed by PADDR[5:2]) and keeps its own
// reference memory updated from the commands it issues; expected responses
// are queued on command issue and popped when the response appears.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NB = DW / 8;
    localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [NB-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [NB-1:0] PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;
    logic [3:0]    state_dbg;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NBYTES(NB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [DW:0]   exp_q[$];          // {err, rdata}
    logic [DW-1:0] ref_mem[16];
    logic [DW-1:0] slave_mem[16];
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // ---------------- driver: one complete transfer ----------------
    task automatic transfer(input bit wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [NB-1:0] strb,
                            input int nwait, input bit perr, input int rsp_lat,
                            input bit hold_cmd);
        logic [3:0]    idx;
        logic [NB-1:0] exp_strb;
        logic [DW-1:0] wval;
        logic [DW:0]   exp;
        logic [DW:0]   got;
        bit            timeout;
        int            acc;

        idx      = addr[5:2];
        exp_strb = wr ? strb : '0;
        timeout  = TO_EN && (nwait >= TO);

        // Reference model: a write lands in memory only if the transfer
        // completes; a timeout returns error with zero data.
        if (timeout) begin
            exp = {1'b1, {DW{1'b0}}};
        end else if (wr) begin
            wval = ref_mem[idx];
            for (int b = 0; b < NB; b++)
                if (strb[b]) wval[b*8 +: 8] = wdata[b*8 +: 8];
            ref_mem[idx] = wval;
            exp = {perr, {DW{1'b0}}};
        end else begin
            exp = {perr, ref_mem[idx]};
        end
        exp_q.push_back(exp);

        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_state", state_dbg, 4'b0001);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom();
        cmd_wdata = $urandom();

        // SETUP
        check("setup_psel", PSEL, 1);
        check("setup_penable", PENABLE, 0);
        check("setup_cmd_ready", cmd_ready, 0);
        check("setup_state", state_dbg, 4'b0010);
        check("setup_paddr", PADDR, addr);
        check("setup_pwrite", PWRITE, wr);
        check("setup_pwdata", PWDATA, wdata);
        check("setup_pstrb", PSTRB, exp_strb);
        PREADY    = 1'b0;
        rsp_ready = 1'($urandom_range(0, 1));
        tick();

        // ACCESS
        acc = timeout ? TO : nwait + 1;
        for (int w = 0; w < acc; w++) begin
            check("access_psel", PSEL, 1);
            check("access_penable", PENABLE, 1);
            check("access_state", state_dbg, 4'b0100);
            check("access_paddr", PADDR, addr);
            check("access_pwrite", PWRITE, wr);
            check("access_pwdata", PWDATA, wdata);
            check("access_pstrb", PSTRB, exp_strb);
            check("access_rsp_valid", rsp_valid, 0);
            rsp_ready = 1'($urandom_range(0, 1));
            if (!timeout && (w == nwait)) begin
                PREADY  = 1'b1;
                PSLVERR = perr;
                if (wr) begin
                    PRDATA = $urandom();
                    wval = slave_mem[PADDR[5:2]];
                    for (int b = 0; b < NB; b++)
                        if (PSTRB[b]) wval[b*8 +: 8] = PWDATA[b*8 +: 8];
                    slave_mem[PADDR[5:2]] = wval;
                end else begin
                    PRDATA = slave_mem[PADDR[5:2]];
                end
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'($urandom_range(0, 1));
                PRDATA  = $urandom();
            end
            tick();
        end
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        rsp_ready = 1'b0;

        // RESP
        got = exp_q.pop_front();
        check("resp_valid", rsp_valid, 1);
        check("resp_psel", PSEL, 0);
        check("resp_penable", PENABLE, 0);
        check("resp_cmd_ready", cmd_ready, 0);
        check("resp_state", state_dbg, 4'b1000);
        check("resp_rdata", rsp_rdata, got[DW-1:0]);
        check("resp_err", rsp_err, got[DW]);
        if (hold_cmd) begin
            cmd_valid = 1'b1;
            cmd_write = 1'($urandom_range(0, 1));
            cmd_strb  = 4'($urandom_range(0, 15));
        end
        for (int i = 0; i < rsp_lat; i++) begin
            tick();
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, got[DW-1:0]);
            check("hold_err", rsp_err, got[DW]);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_psel", PSEL, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("done_rsp_valid", rsp_valid, 0);
        check("done_cmd_ready", cmd_ready, 1);
        check("done_psel", PSEL, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [DW-1:0] v;
        logic [AW-1:0] a;

        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = $urandom();
            ref_mem[i]   = v;
            slave_mem[i] = v;
        end
        ref_mem[8]   = 32'h1234_5678;
        slave_mem[8] = 32'h1234_5678;

        // Reset values
        tick();
        tick();
        check("rst_state", state_dbg, 4'b0001);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_pstrb", PSTRB, 0);
        check("rst_pwrite", PWRITE, 0);
        PRESET = 1'b0;
        tick();

        // Plain write, zero wait states
        transfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0, 1'b0);
        // Read with three wait states (last cycle before any timeout)
        transfer(1'b0, 32'h20, 32'hA5A5_A5A5, 4'hF, 3, 1'b0, 0, 1'b0);
        // Slave error, then a clean read
        transfer(1'b0, 32'h24, 32'h0, 4'h0, 1, 1'b1, 0, 1'b0);
        transfer(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0, 0, 1'b0);
        // Response back-pressure with a pending command, then that command
        transfer(1'b1, 32'h10, 32'h0102_0304, 4'h5, 0, 1'b0, 5, 1'b1);
        transfer(1'b0, 32'h10, 32'h0, 4'h3, 2, 1'b0, 1, 1'b0);

        // Reset during ACCESS drops the transfer
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h30;
        tick();
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        tick();
        check("pre_rst_penable", PENABLE, 1);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        check("mid_rst_psel", PSEL, 0);
        check("mid_rst_penable", PENABLE, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_state", state_dbg, 4'b0001);

        // Long wait: times out with the timeout build, completes otherwise
        transfer(1'b0, 32'h34, 32'h0, 4'h0, 10, 1'b0, 0, 1'b0);
        transfer(1'b1, 32'h38, 32'hCAFE_F00D, 4'hF, 6, 1'b0, 0, 1'b0);
        transfer(1'b0, 32'h38, 32'h0, 4'h0, 0, 1'b0, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            a = $urandom();
            a[1:0] = 2'b00;
            transfer(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
